mem_resp: RTL and testbench
===========================

# mem_resp

Memory/IO responder for the execution unit's data port. Takes the request that `exec` drives (`addr`, `wr_data`, `we`, `m_io`, `byteop`) qualified by the microcode memory-op bit. Runs it on the 16-bit word-aligned external bus, splitting odd-address word accesses into two byte-lane cycles. Returns `memout` with a one-cycle `mem_rdy` completion pulse, which releases the execution unit's register-write block.

## Interface

Parameters:
- `TIMEOUT`, default 255: cycles `ext_stb` may wait for `ext_ack` before the beat is forcibly completed.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `mem_op` in 1: request valid (microcode memory-op bit).
- `addr` in 20: byte address; IO cycles use `addr[15:0]`.
- `wr_data` in 16: write data; byte writes use `[7:0]`.
- `we` in 1: 1 = write, 0 = read.
- `m_io` in 1: 1 = IO space, 0 = memory.
- `byteop` in 1: 1 = byte access, 0 = word.
- `memout` out 16: read data; valid while `mem_rdy`, held until next completion.
- `mem_rdy` out 1: one-cycle completion pulse.
- `ext_adr` out 19: word address (byte address >> 1).
- `ext_dat_o` out 16: write data on lanes.
- `ext_dat_i` in 16: read data.
- `ext_sel` out 2: lane enables; [0] = even byte, [1] = odd byte.
- `ext_we` out 1: write strobe qualifier.
- `ext_io` out 1: IO-space qualifier.
- `ext_stb` out 1: beat request.
- `ext_ack` in 1: beat accepted/data valid.
- `timeout` out 1: one-cycle pulse when a beat times out.

## Operation

- FSM states: IDLE, LO, HI, DONE.
- IDLE: when `mem_op`=1, latch `addr`, `wr_data`, `we`, `m_io`, `byteop`; go to LO. Inputs are ignored outside IDLE.
- Split rule: a word access with `addr[0]`=1 needs two beats. All others need one.
- LO beat, word address A>>1:
  - Aligned word: `ext_sel`=11.
  - Byte: `ext_sel`=01 if A even, 10 if odd.
  - Split word: `ext_sel`=10.
- HI beat (split only): word address (A+1)>>1, `ext_sel`=01.
  - Memory: A+1 wraps modulo 2^20 (FFFFF -> 00000).
  - IO: A+1 wraps modulo 2^16 (FFFF -> 0000).
- Write lane steering:
  - Byte write drives `wr_data[7:0]` on both lanes.
  - Split word: LO drives `wr_data[7:0]` on the odd lane; HI drives `wr_data[15:8]` on the even lane.
- Read assembly:
  - Aligned word: `ext_dat_i`.
  - Byte: the selected lane in `[7:0]`, with `[15:8]`=00.
  - Split word: LO odd lane -> `memout[7:0]`; HI even lane -> `memout[15:8]`.
- A beat completes on the edge where `ext_stb && ext_ack`. After LO, go to HI if split, else to DONE. After HI, go to DONE.
- DONE: `mem_rdy`=1 for exactly one cycle, then return to IDLE.
  - A `mem_op` present in DONE is not accepted; it is sampled in the following IDLE cycle. This prevents double-issue while the execution unit advances its micro-instruction.
- Timeout: a per-beat counter resets at beat start and increments while `ext_stb && !ext_ack`.
  - At `TIMEOUT` the beat completes as if acked, with read lanes = FF, and `timeout` pulses.
  - Write data is dropped.
- `mem_op` deasserting mid-transaction has no effect; the transaction finishes and `mem_rdy` still pulses.

## Timing

- Reset (async, immediate) values:
  - `ext_stb`=0, `ext_we`=0, `ext_io`=0, `ext_sel`=00, `ext_adr`=0, `ext_dat_o`=0.
  - `memout`=0000, `mem_rdy`=0, `timeout`=0.
  - FSM=IDLE, counter=0.
- Reset mid-transaction abandons the beat; no `mem_rdy`.
- All outputs are registered.
- Request sampled in cycle 0; `ext_stb` high from cycle 1.
- `ext_stb` stays high continuously across LO->HI; address, sel and data change on the LO completion edge.
- Zero-wait aligned/byte access: ack in cycle 1, `mem_rdy` in cycle 2.
- Zero-wait split access: acks in cycles 1 and 2, `mem_rdy` in cycle 3.
- Each wait state adds one cycle per beat.
- Peak throughput: one transaction per 3 cycles (IDLE, LO, DONE).

## Structure

- `mem_resp_pkg`:
  - State enum (IDLE/LO/HI/DONE).
  - `SEL_EVEN`=01, `SEL_ODD`=10, `SEL_WORD`=11.
  - Open-bus byte FF.
- One combinational sub-module, `mem_resp_lane`: given latched addr bit 0, byteop, beat (LO/HI) and wr_data, produces `ext_sel` and `ext_dat_o`. It also produces the read-lane select used for `memout` assembly.

## Test plan

- Aligned word read at 0x12344, `ext_dat_i`=BEEF, ack in cycle 1 -> `ext_adr`=091A2, sel=11; `mem_rdy` in cycle 2 with `memout`=BEEF.
- Odd byte write 0x00011, `wr_data`=00A5 -> one beat, `ext_adr`=00008, sel=10, `ext_dat_o`=A5A5, `ext_we`=1; `mem_rdy` in cycle 2.
- Split word read at 0xFFFFF: LO returns 3400, HI returns 0012 -> LO `ext_adr`=7FFFF sel=10, HI `ext_adr`=00000 sel=01; `memout`=1234, `mem_rdy` in cycle 3.
- IO split word write, `addr`=0x0FFFF, `wr_data`=ABCD -> `ext_io`=1; LO adr 07FFF sel=10 odd lane CD; HI adr 00000 sel=01 even lane AB.
- Byte read with `ext_ack` never asserted, `TIMEOUT`=4 -> `timeout` pulses after 4 wait cycles; `memout`=00FF, single `mem_rdy`.
- Back-to-back: `mem_op` held high across DONE -> exactly one `mem_rdy` per accepted request. Async `rst` low during HI -> `ext_stb`=0 immediately, FSM=IDLE, no `mem_rdy`.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the execution-unit memory/IO responder.
// Also holds the byte-to-word address helper used for both memory and IO space.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_EVEN = 2'b01;
    localparam logic [1:0] SEL_ODD  = 2'b10;
    localparam logic [1:0] SEL_WORD = 2'b11;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    // IO space only decodes 16 address bits, so its word address is confined to 15 bits.
    function automatic logic [18:0] word_adr(input logic [19:0] a, input logic io);
        logic [19:0] m;
        m = io ? {4'h0, a[15:0]} : a;
        return m[19:1];
    endfunction

endpackage

// File: rtl/mem_resp_if.sv
// External 16-bit word-aligned bus: one strobe/ack beat per lane group.
// master = responder driving the bus, slave = memory/IO device.
interface mem_resp_if;
    logic [18:0] ext_adr;
    logic [15:0] ext_dat_o;
    logic [15:0] ext_dat_i;
    logic [1:0]  ext_sel;
    logic        ext_we;
    logic        ext_io;
    logic        ext_stb;
    logic        ext_ack;

    modport master (
        output ext_adr, ext_dat_o, ext_sel, ext_we, ext_io, ext_stb,
        input  ext_dat_i, ext_ack
    );

    modport slave (
        input  ext_adr, ext_dat_o, ext_sel, ext_we, ext_io, ext_stb,
        output ext_dat_i, ext_ack
    );
endinterface

// File: rtl/mem_resp_lane.sv
// Lane steering for one bus beat: byte enables, write-data placement, read lane pick.
// Purely combinational; no latency, no flow control.
module mem_resp_lane
    import mem_resp_pkg::*;
(
    input  logic        a0,
    input  logic        byteop,
    input  logic        hi,
    input  logic [15:0] wr_data,
    output logic [1:0]  sel,
    output logic [15:0] dat_o,
    output logic        rd_odd
);
    always_comb begin
        sel    = SEL_WORD;
        dat_o  = wr_data;
        rd_odd = 1'b0;
        if (byteop) begin
            sel    = a0 ? SEL_ODD : SEL_EVEN;
            dat_o  = {2{wr_data[7:0]}};
            rd_odd = a0;
        end else if (a0) begin
            // Split word: low byte lives in the odd lane of word A, high byte in the even lane of A+1.
            if (hi) begin
                sel    = SEL_EVEN;
                dat_o  = {2{wr_data[15:8]}};
                rd_odd = 1'b0;
            end else begin
                sel    = SEL_ODD;
                dat_o  = {2{wr_data[7:0]}};
                rd_odd = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_resp.sv
// Memory/IO responder: runs exec requests on the 16-bit bus, splitting odd word accesses into two beats.
// Latency: mem_rdy 2 cycles after request (3 when split), plus one cycle per wait state per beat.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_op,
    input  logic [19:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        m_io,
    input  logic        byteop,
    output logic [15:0] memout,
    output logic        mem_rdy,
    output logic        timeout,
    mem_resp_if.master  ext
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [19:0]   adr_q, adr_d;
    logic [15:0]   wr_q, wr_d;
    logic          byte_q, byte_d;
    logic          split_q, split_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic          rd_odd_q, rd_odd_d;
    logic [18:0]   ext_adr_q, ext_adr_d;
    logic [15:0]   ext_dat_o_q, ext_dat_o_d;
    logic [1:0]    ext_sel_q, ext_sel_d;
    logic          ext_we_q, ext_we_d;
    logic          ext_io_q, ext_io_d;
    logic          ext_stb_q, ext_stb_d;
    logic [15:0]   memout_q, memout_d;
    logic          mem_rdy_q, mem_rdy_d;
    logic          timeout_q, timeout_d;

    logic          idle;
    logic          lane_a0, lane_byte, lane_hi, lane_rd_odd;
    logic [15:0]   lane_wr, lane_dat;
    logic [1:0]    lane_sel;
    logic          beat_exp, beat_done;
    logic [15:0]   rd_dat;
    logic [7:0]    rd_byte;
    logic [19:0]   adr_inc;

    // In IDLE the lane logic looks at the incoming request; afterwards it prepares the HI beat.
    assign idle      = (state_q == IDLE);
    assign lane_a0   = idle ? addr[0] : adr_q[0];
    assign lane_byte = idle ? byteop  : byte_q;
    assign lane_wr   = idle ? wr_data : wr_q;
    assign lane_hi   = !idle;

    mem_resp_lane u_lane (
        .a0      (lane_a0),
        .byteop  (lane_byte),
        .hi      (lane_hi),
        .wr_data (lane_wr),
        .sel     (lane_sel),
        .dat_o   (lane_dat),
        .rd_odd  (lane_rd_odd)
    );

    assign beat_exp  = ext_stb_q && !ext.ext_ack && (cnt_q == CNT_LAST);
    assign beat_done = (ext_stb_q && ext.ext_ack) || beat_exp;
    assign rd_dat    = beat_exp ? {2{OPEN_BUS}} : ext.ext_dat_i;
    assign rd_byte   = rd_odd_q ? rd_dat[15:8] : rd_dat[7:0];
    assign adr_inc   = adr_q + 20'd1;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        wr_d        = wr_q;
        byte_d      = byte_q;
        split_d     = split_q;
        lo_byte_d   = lo_byte_q;
        rd_odd_d    = rd_odd_q;
        ext_adr_d   = ext_adr_q;
        ext_dat_o_d = ext_dat_o_q;
        ext_sel_d   = ext_sel_q;
        ext_we_d    = ext_we_q;
        ext_io_d    = ext_io_q;
        ext_stb_d   = ext_stb_q;
        memout_d    = memout_q;
        mem_rdy_d   = 1'b0;
        timeout_d   = 1'b0;
        cnt_d       = (ext_stb_q && !ext.ext_ack) ? cnt_q + CW'(1) : cnt_q;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d     = LO;
                    adr_d       = addr;
                    wr_d        = wr_data;
                    byte_d      = byteop;
                    split_d     = !byteop && addr[0];
                    ext_adr_d   = word_adr(addr, m_io);
                    ext_sel_d   = lane_sel;
                    ext_dat_o_d = lane_dat;
                    rd_odd_d    = lane_rd_odd;
                    ext_we_d    = we;
                    ext_io_d    = m_io;
                    ext_stb_d   = 1'b1;
                    cnt_d       = '0;
                end
            end
            LO: begin
                if (beat_done) begin
                    timeout_d = beat_exp;
                    if (split_q) begin
                        // Strobe stays up; only address, lanes and data move to the HI beat.
                        state_d     = HI;
                        ext_adr_d   = word_adr(adr_inc, ext_io_q);
                        ext_sel_d   = lane_sel;
                        ext_dat_o_d = lane_dat;
                        rd_odd_d    = lane_rd_odd;
                        lo_byte_d   = rd_byte;
                        cnt_d       = '0;
                    end else begin
                        state_d   = DONE;
                        ext_stb_d = 1'b0;
                        ext_we_d  = 1'b0;
                        ext_sel_d = SEL_NONE;
                        mem_rdy_d = 1'b1;
                        memout_d  = byte_q ? {8'h00, rd_byte} : rd_dat;
                    end
                end
            end
            HI: begin
                if (beat_done) begin
                    timeout_d = beat_exp;
                    state_d   = DONE;
                    ext_stb_d = 1'b0;
                    ext_we_d  = 1'b0;
                    ext_sel_d = SEL_NONE;
                    mem_rdy_d = 1'b1;
                    memout_d  = {rd_byte, lo_byte_q};
                end
            end
            DONE: begin
                // A request still asserted here is only sampled once back in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            wr_q        <= '0;
            byte_q      <= 1'b0;
            split_q     <= 1'b0;
            cnt_q       <= '0;
            lo_byte_q   <= '0;
            rd_odd_q    <= 1'b0;
            ext_adr_q   <= '0;
            ext_dat_o_q <= '0;
            ext_sel_q   <= SEL_NONE;
            ext_we_q    <= 1'b0;
            ext_io_q    <= 1'b0;
            ext_stb_q   <= 1'b0;
            memout_q    <= '0;
            mem_rdy_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            wr_q        <= wr_d;
            byte_q      <= byte_d;
            split_q     <= split_d;
            cnt_q       <= cnt_d;
            lo_byte_q   <= lo_byte_d;
            rd_odd_q    <= rd_odd_d;
            ext_adr_q   <= ext_adr_d;
            ext_dat_o_q <= ext_dat_o_d;
            ext_sel_q   <= ext_sel_d;
            ext_we_q    <= ext_we_d;
            ext_io_q    <= ext_io_d;
            ext_stb_q   <= ext_stb_d;
            memout_q    <= memout_d;
            mem_rdy_q   <= mem_rdy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ext.ext_adr   = ext_adr_q;
    assign ext.ext_dat_o = ext_dat_o_q;
    assign ext.ext_sel   = ext_sel_q;
    assign ext.ext_we    = ext_we_q;
    assign ext.ext_io    = ext_io_q;
    assign ext.ext_stb   = ext_stb_q;
    assign memout        = memout_q;
    assign mem_rdy       = mem_rdy_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: directed vector table, reset/back-to-back sequences, and random
// transactions checked against a byte-addressed reference memory.
module tb_mem_resp;
    localparam int TO    = 4;
    localparam int NEVER = 1000;

    logic        clk, rst, mem_op, we, m_io, byteop, mem_rdy, timeout;
    logic [19:0] addr;
    logic [15:0] wr_data, memout;

    mem_resp_if ifc ();

    mem_resp #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_op(mem_op), .addr(addr), .wr_data(wr_data),
        .we(we), .m_io(m_io), .byteop(byteop), .memout(memout), .mem_rdy(mem_rdy),
        .timeout(timeout), .ext(ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miss    = 0;

    // Observations of the most recent transaction.
    logic [18:0] obs_adr [2];
    logic [1:0]  obs_sel [2];
    logic [15:0] obs_dat [2];
    logic        obs_we, obs_io;
    int          n_beats, n_to, got_lat;
    logic [15:0] got_mo;

    // Bus device memory and the independent reference memory, keyed by {io, byte address}.
    logic [7:0] smem [logic [20:0]];
    logic [7:0] rmem [logic [20:0]];

    function automatic logic [20:0] key(input logic io, input logic [19:0] a);
        return io ? {1'b1, 4'h0, a[15:0]} : {1'b0, a};
    endfunction

    function automatic logic [7:0] dflt(input logic [20:0] k);
        return k[7:0] ^ {k[20], k[14:8]};
    endfunction

    function automatic logic [7:0] s_rd(input logic [20:0] k);
        return smem.exists(k) ? smem[k] : dflt(k);
    endfunction

    function automatic logic [7:0] r_rd(input logic [20:0] k);
        return rmem.exists(k) ? rmem[k] : dflt(k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Issue one request and act as the bus device; w0/w1 are wait states per beat (NEVER = no ack).
    task automatic run_txn(input logic [19:0] a, input logic [15:0] wd, input logic w,
                           input logic io, input logic bo, input int w0, input int w1,
                           input logic [15:0] rd0, input logic [15:0] rd1,
                           input bit use_mem, input bit hold);
        int wt [2];
        logic [15:0] rdv [2];
        int b, wc, n;
        bit done;
        logic [19:0] ba;
        wt[0] = w0; wt[1] = w1; rdv[0] = rd0; rdv[1] = rd1;
        @(negedge clk);
        mem_op = 1'b1; addr = a; wr_data = wd; we = w; m_io = io; byteop = bo;
        @(posedge clk); #1;
        mem_op = hold; addr = 20'($urandom); wr_data = 16'($urandom);
        we = 1'($urandom); m_io = 1'($urandom); byteop = 1'($urandom);
        b = 0; wc = 0; n = 1; done = 0; n_beats = 0; n_to = 0; got_lat = -1; got_mo = 'x;
        while (!done && n < 60) begin
            if (timeout) n_to++;
            if (mem_rdy) begin
                got_lat = n; got_mo = memout; done = 1;
            end else begin
                ifc.ext_ack = 1'b0;
                ifc.ext_dat_i = 16'($urandom);
                if (ifc.ext_stb && b < 2) begin
                    if (wc == 0) begin
                        obs_adr[b] = ifc.ext_adr; obs_sel[b] = ifc.ext_sel;
                        obs_dat[b] = ifc.ext_dat_o; obs_we = ifc.ext_we; obs_io = ifc.ext_io;
                        n_beats++;
                    end
                    if (wc == wt[b]) begin
                        ifc.ext_ack = 1'b1;
                        if (use_mem) begin
                            ba = {ifc.ext_adr, 1'b0};
                            ifc.ext_dat_i = {s_rd(key(ifc.ext_io, ba | 20'd1)), s_rd(key(ifc.ext_io, ba))};
                            if (ifc.ext_we) begin
                                if (ifc.ext_sel[0]) smem[key(ifc.ext_io, ba)] = ifc.ext_dat_o[7:0];
                                if (ifc.ext_sel[1]) smem[key(ifc.ext_io, ba | 20'd1)] = ifc.ext_dat_o[15:8];
                            end
                        end else begin
                            ifc.ext_dat_i = rdv[b];
                        end
                        b++; wc = 0;
                    end else if (wc == TO - 1) begin
                        b++; wc = 0;
                    end else begin
                        wc++;
                    end
                end
                @(posedge clk); #1;
                n++;
            end
        end
        ifc.ext_ack = 1'b0;
        @(posedge clk); #1;
        chk("rdy_pulse", 32'(mem_rdy), 32'd0);
        chk("no_reissue", 32'(ifc.ext_stb), 32'd0);
    endtask

    typedef struct {
        logic [19:0] a;   logic [15:0] wd; logic w; logic io; logic bo;
        int w0; int w1;   logic [15:0] rd0; logic [15:0] rd1;
        int nb;           logic [18:0] adr0; logic [18:0] adr1;
        logic [1:0] sel0; logic [1:0] sel1;
        logic [15:0] dat0; logic [15:0] dm0; logic [15:0] dat1; logic [15:0] dm1;
        logic [15:0] mo;  int lat; int nto;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] a, a1;
        logic [15:0] wd, exp_mo;
        logic        w, io, bo, split, t0, t1, thi;
        logic [7:0]  lo, hi;
        int          w0, w1, exp_lat;

        //        a          wd        w     io    bo   w0     w1     rd0       rd1      nb adr0        adr1        sel0   sel1   dat0      dm0       dat1      dm1       mo        lat nto
        tbl[0]  = '{20'h12344, 16'h0000, 1'b0, 1'b0, 1'b0, 0,     0,     16'hBEEF, 16'h0000, 1, 19'h091A2, 19'h00000, 2'b11, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 2, 0};
        tbl[1]  = '{20'h00011, 16'h00A5, 1'b1, 1'b0, 1'b1, 0,     0,     16'h0000, 16'h0000, 1, 19'h00008, 19'h00000, 2'b10, 2'b00, 16'hA5A5, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2, 0};
        tbl[2]  = '{20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 0,     0,     16'h3400, 16'h0012, 2, 19'h7FFFF, 19'h00000, 2'b10, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 3, 0};
        tbl[3]  = '{20'h0FFFF, 16'hABCD, 1'b1, 1'b1, 1'b0, 0,     0,     16'h0000, 16'h0000, 2, 19'h07FFF, 19'h00000, 2'b10, 2'b01, 16'hCD00, 16'hFF00, 16'h00AB, 16'h00FF, 16'h0000, 3, 0};
        tbl[4]  = '{20'h00200, 16'h0000, 1'b0, 1'b0, 1'b1, NEVER, 0,     16'h0000, 16'h0000, 1, 19'h00100, 19'h00000, 2'b01, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 5, 1};
        tbl[5]  = '{20'h00100, 16'h0000, 1'b0, 1'b0, 1'b0, 2,     0,     16'h1357, 16'h0000, 1, 19'h00080, 19'h00000, 2'b11, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1357, 4, 0};
        tbl[6]  = '{20'h00003, 16'h0000, 1'b0, 1'b0, 1'b0, 1,     1,     16'hAA00, 16'h00BB, 2, 19'h00001, 19'h00002, 2'b10, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBBAA, 5, 0};
        tbl[7]  = '{20'h00005, 16'h0000, 1'b0, 1'b0, 1'b0, 0,     NEVER, 16'h7700, 16'h0000, 2, 19'h00002, 19'h00003, 2'b10, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF77, 6, 1};
        tbl[8]  = '{20'h00007, 16'h0000, 1'b0, 1'b0, 1'b1, 0,     0,     16'h5A00, 16'h0000, 1, 19'h00003, 19'h00000, 2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h005A, 2, 0};
        tbl[9]  = '{20'h30010, 16'h1234, 1'b1, 1'b1, 1'b0, 0,     0,     16'h0000, 16'h0000, 1, 19'h00008, 19'h00000, 2'b11, 2'b00, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2, 0};
        tbl[10] = '{20'h00004, 16'h5678, 1'b1, 1'b0, 1'b0, NEVER, 0,     16'h0000, 16'h0000, 1, 19'h00002, 19'h00000, 2'b11, 2'b00, 16'h5678, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 5, 1};
        tbl[11] = '{20'h00040, 16'h12C3, 1'b1, 1'b0, 1'b1, 0,     0,     16'h0000, 16'h0000, 1, 19'h00020, 19'h00000, 2'b01, 2'b00, 16'hC3C3, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 2, 0};

        rst = 1'b0; mem_op = 1'b0; addr = '0; wr_data = '0; we = 1'b0; m_io = 1'b0; byteop = 1'b0;
        ifc.ext_ack = 1'b0; ifc.ext_dat_i = '0;
        #12;
        chk("rst_stb",   32'(ifc.ext_stb),   32'd0);
        chk("rst_we",    32'(ifc.ext_we),    32'd0);
        chk("rst_io",    32'(ifc.ext_io),    32'd0);
        chk("rst_sel",   32'(ifc.ext_sel),   32'd0);
        chk("rst_adr",   32'(ifc.ext_adr),   32'd0);
        chk("rst_dat_o", 32'(ifc.ext_dat_o), 32'd0);
        chk("rst_memout",32'(memout),        32'd0);
        chk("rst_rdy",   32'(mem_rdy),       32'd0);
        chk("rst_tmo",   32'(timeout),       32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].a, tbl[i].wd, tbl[i].w, tbl[i].io, tbl[i].bo, tbl[i].w0, tbl[i].w1,
                    tbl[i].rd0, tbl[i].rd1, 1'b0, 1'b0);
            chk($sformatf("v%0d_beats", i), 32'(n_beats), 32'(tbl[i].nb));
            chk($sformatf("v%0d_adr0", i),  32'(obs_adr[0]), 32'(tbl[i].adr0));
            chk($sformatf("v%0d_sel0", i),  32'(obs_sel[0]), 32'(tbl[i].sel0));
            chk($sformatf("v%0d_we", i),    32'(obs_we), 32'(tbl[i].w));
            chk($sformatf("v%0d_io", i),    32'(obs_io), 32'(tbl[i].io));
            if (tbl[i].nb == 2) begin
                chk($sformatf("v%0d_adr1", i), 32'(obs_adr[1]), 32'(tbl[i].adr1));
                chk($sformatf("v%0d_sel1", i), 32'(obs_sel[1]), 32'(tbl[i].sel1));
            end
            if (tbl[i].w) begin
                chk($sformatf("v%0d_dat0", i), 32'(obs_dat[0] & tbl[i].dm0), 32'(tbl[i].dat0));
                if (tbl[i].nb == 2)
                    chk($sformatf("v%0d_dat1", i), 32'(obs_dat[1] & tbl[i].dm1), 32'(tbl[i].dat1));
            end else begin
                chk($sformatf("v%0d_memout", i), 32'(got_mo), 32'(tbl[i].mo));
            end
            chk($sformatf("v%0d_lat", i), 32'(got_lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d_tmo", i), 32'(n_to), 32'(tbl[i].nto));
        end

        // Back-to-back: request held through DONE must not be issued twice.
        run_txn(20'h00010, 16'h0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h1111, 16'h0, 1'b0, 1'b1);
        chk("b2b_first_mo",  32'(got_mo),  32'h1111);
        chk("b2b_first_lat", 32'(got_lat), 32'd2);
        run_txn(20'h00012, 16'h0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h2222, 16'h0, 1'b0, 1'b0);
        chk("b2b_second_mo",  32'(got_mo),  32'h2222);
        chk("b2b_second_lat", 32'(got_lat), 32'd2);

        // Async reset while the HI beat is on the bus.
        @(negedge clk);
        mem_op = 1'b1; addr = 20'h00101; we = 1'b0; m_io = 1'b0; byteop = 1'b0;
        @(posedge clk); #1;
        mem_op = 1'b0;
        ifc.ext_ack = 1'b1; ifc.ext_dat_i = 16'h1100;
        @(posedge clk); #1;
        ifc.ext_ack = 1'b0;
        chk("hi_stb", 32'(ifc.ext_stb), 32'd1);
        chk("hi_sel", 32'(ifc.ext_sel), 32'(2'b01));
        #2 rst = 1'b0;
        #1;
        chk("arst_stb", 32'(ifc.ext_stb), 32'd0);
        chk("arst_rdy", 32'(mem_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int rdy_seen, stb_seen;
            rdy_seen = 0; stb_seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                if (mem_rdy) rdy_seen++;
                if (ifc.ext_stb) stb_seen++;
            end
            chk("arst_no_rdy", 32'(rdy_seen), 32'd0);
            chk("arst_idle",   32'(stb_seen), 32'd0);
        end

        // Random traffic against the byte-level reference model.
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 3))
                0: a = 20'h00000;
                1: a = 20'hFFFF8;
                2: a = 20'h0FFF8;
                default: a = 20'h5FFF8;
            endcase
            a  = a + 20'($urandom_range(0, 15));
            wd = 16'($urandom);
            w  = 1'($urandom); io = 1'($urandom); bo = 1'($urandom);
            w0 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 2));
            w1 = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 2));
            split = !bo && a[0];
            a1    = a + 20'd1;
            t0    = (w0 >= TO);
            t1    = split && (w1 >= TO);
            thi   = split ? t1 : t0;
            lo    = t0  ? 8'hFF : r_rd(key(io, a));
            hi    = thi ? 8'hFF : r_rd(key(io, a1));
            exp_mo  = bo ? {8'h00, lo} : {hi, lo};
            exp_lat = 1 + (t0 ? TO : w0 + 1) + (split ? (t1 ? TO : w1 + 1) : 0);
            if (w) begin
                if (!t0) rmem[key(io, a)] = wd[7:0];
                if (!bo && !thi) rmem[key(io, a1)] = wd[15:8];
            end
            run_txn(a, wd, w, io, bo, w0, w1, 16'h0, 16'h0, 1'b1, 1'b0);
            if (!w) chk($sformatf("r%0d_memout", t), 32'(got_mo), 32'(exp_mo));
            chk($sformatf("r%0d_lat", t), 32'(got_lat), 32'(exp_lat));
            chk($sformatf("r%0d_tmo", t), 32'(n_to), 32'(int'(t0) + int'(t1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end
endmodule
